// File: rtl/mac_lane_scheduler_pkg.sv
// Shared convolution-engine definitions used by the MAC lane scheduler.
//   - MAC pipeline latencies and the resulting default lane count
//   - FP32 positive zero, used for bubble operands and empty accumulators
//   - Scheduler state encoding
package mac_lane_scheduler_pkg;

    localparam int MUL_LATENCY       = 5;
    localparam int ADD_LATENCY       = 7;
    // One accumulator lane per pipeline stage keeps the MAC fully busy
    // while each lane only sees its own previous partial sum.
    localparam int MAC_LANES_DEFAULT = MUL_LATENCY + ADD_LATENCY;

    localparam logic [31:0] FP32_ZERO = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } sched_state_t;

endpackage

// File: rtl/mac_lane_scheduler.sv
// mac_lane_scheduler
// Interleaves Lanes independent FP32 dot products through one external
// multiply-accumulate pipeline whose total latency equals Lanes. Each
// pipeline slot s permanently owns lane s, so a lane's partial sum comes
// back from the MAC exactly when that lane's slot comes round again.
//
// Ports
//   clk, aclr          clock, asynchronous active-high reset
//   start, len         job request (sampled in IDLE), terms per lane
//   busy, done         job in progress, one-cycle completion pulse
//   op_valid/op_ready  operand handshake, lane-major operand order
//   op_w, op_i         FP32 weight / input operand
//   mac_nop            1 = bubble slot in the MAC
//   mac_w, mac_i       MAC multiplier operands
//   mac_o              MAC accumulator input (partial sum for this slot)
//   mac_data           MAC result, Lanes cycles after issue
//   res_valid/lane/data  final lane sums, lanes 0..Lanes-1 in order
module mac_lane_scheduler
    import mac_lane_scheduler_pkg::*;
#(
    parameter int DataWidth = 32,
    parameter int Lanes     = MAC_LANES_DEFAULT,
    parameter int LenWidth  = 16,
    localparam int LaneWidth = (Lanes > 1) ? $clog2(Lanes) : 1
) (
    input  logic                 clk,
    input  logic                 aclr,
    input  logic                 start,
    input  logic [LenWidth-1:0]  len,
    output logic                 busy,
    output logic                 done,
    input  logic                 op_valid,
    output logic                 op_ready,
    input  logic [DataWidth-1:0] op_w,
    input  logic [DataWidth-1:0] op_i,
    output logic                 mac_nop,
    output logic [DataWidth-1:0] mac_w,
    output logic [DataWidth-1:0] mac_i,
    output logic [DataWidth-1:0] mac_o,
    input  logic [DataWidth-1:0] mac_data,
    output logic                 res_valid,
    output logic [LaneWidth-1:0] res_lane,
    output logic [DataWidth-1:0] res_data
);

    localparam logic [LaneWidth-1:0] LAST_LANE = LaneWidth'(Lanes - 1);
    localparam logic [DataWidth-1:0] ZERO_WORD = DataWidth'(FP32_ZERO);

    sched_state_t         state_reg, state_next;
    logic [LaneWidth-1:0] slot_reg, slot_next;
    logic [LaneWidth-1:0] exp_reg, exp_next;
    logic [LenWidth-1:0]  round_reg, round_next;
    logic [LenWidth-1:0]  len_reg, len_next;
    logic [Lanes-1:0]     final_reg, final_next;
    logic                 res_valid_reg, res_valid_next;
    logic [LaneWidth-1:0] res_lane_reg, res_lane_next;
    logic [DataWidth-1:0] res_data_reg, res_data_next;
    logic                 done_reg, done_next;

    logic             active;
    logic             accept;
    logic             last_lane;
    logic             last_round;
    logic             slot_wrap;
    logic             lane_empty;
    logic             harvest;
    logic [Lanes-1:0] harvest_hit;

    assign active     = (state_reg == ST_ISSUE) || (state_reg == ST_DRAIN);
    // Operands are lane-major, so the next operand may only enter in the
    // slot that owns its lane; anything else would mix lanes.
    assign op_ready   = (state_reg == ST_ISSUE) && (slot_reg == exp_reg);
    assign accept     = op_valid && op_ready;
    assign last_lane  = (exp_reg == LAST_LANE);
    assign last_round = (round_reg == (len_reg - LenWidth'(1)));
    assign slot_wrap  = (slot_reg == LAST_LANE);

    // A lane with no issued terms yet must start from zero rather than
    // whatever an earlier job left circulating in the MAC pipeline.
    assign lane_empty = (round_reg == '0) && (slot_reg >= exp_reg);

    // The final partial sum of lane gi returns in slot gi one rotation
    // after its last term was issued.
    genvar gi;
    generate
        for (gi = 0; gi < Lanes; gi++) begin : g_harvest
            assign harvest_hit[gi] = active && final_reg[gi]
                                     && (slot_reg == LaneWidth'(gi));
        end
    endgenerate
    assign harvest = |harvest_hit;

    // Bubble slots recirculate the lane's partial sum untouched (O + 0*0).
    assign mac_nop   = !accept;
    assign mac_w     = accept ? op_w : ZERO_WORD;
    assign mac_i     = accept ? op_i : ZERO_WORD;
    assign mac_o     = (active && !lane_empty) ? mac_data : ZERO_WORD;

    assign busy      = (state_reg != ST_IDLE);
    assign done      = done_reg;
    assign res_valid = res_valid_reg;
    assign res_lane  = res_lane_reg;
    assign res_data  = res_data_reg;

    always_comb begin
        state_next     = state_reg;
        slot_next      = slot_reg;
        exp_next       = exp_reg;
        round_next     = round_reg;
        len_next       = len_reg;
        final_next     = final_reg;
        res_valid_next = 1'b0;
        res_lane_next  = res_lane_reg;
        res_data_next  = res_data_reg;
        done_next      = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start && (len != '0)) begin
                    len_next   = len;
                    slot_next  = '0;
                    exp_next   = '0;
                    round_next = '0;
                    final_next = '0;
                    state_next = ST_ISSUE;
                end
            end

            ST_ISSUE, ST_DRAIN: begin
                slot_next = slot_wrap ? '0 : slot_reg + LaneWidth'(1);

                if (accept) begin
                    exp_next = last_lane ? '0 : exp_reg + LaneWidth'(1);
                    if (last_lane) begin
                        round_next = round_reg + LenWidth'(1);
                        if (last_round) begin
                            state_next = ST_DRAIN;
                        end
                    end
                end

                for (int j = 0; j < Lanes; j++) begin
                    if (accept && last_round && (exp_reg == LaneWidth'(j))) begin
                        final_next[j] = 1'b1;
                    end
                    if (harvest_hit[j]) begin
                        final_next[j] = 1'b0;
                    end
                end

                if (harvest) begin
                    res_valid_next = 1'b1;
                    res_lane_next  = slot_reg;
                    res_data_next  = mac_data;
                    // Lanes finish in order, so the last lane closes the job.
                    if (slot_wrap) begin
                        done_next  = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state_reg     <= ST_IDLE;
            slot_reg      <= '0;
            exp_reg       <= '0;
            round_reg     <= '0;
            len_reg       <= '0;
            final_reg     <= '0;
            res_valid_reg <= 1'b0;
            res_lane_reg  <= '0;
            res_data_reg  <= '0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            slot_reg      <= slot_next;
            exp_reg       <= exp_next;
            round_reg     <= round_next;
            len_reg       <= len_next;
            final_reg     <= final_next;
            res_valid_reg <= res_valid_next;
            res_lane_reg  <= res_lane_next;
            res_data_reg  <= res_data_next;
            done_reg      <= done_next;
        end
    end

endmodule

// File: doc/mac_lane_scheduler.md
MAC_LANE_SCHEDULER -- requirements
Module: mac_lane_scheduler

Interface
REQ-001 SHALL have parameters: DataWidth, 32, operand/result width; Lanes, 12, interleaved accumulators (equals total MAC latency 5+7); LenWidth, 16, term-count width.
REQ-002 SHALL have one clock and an asynchronous active-high reset, named as below.
REQ-003 SHALL provide ports (name  direction  width  meaning):
 clk  in  1  clock
 aclr  in  1  asynchronous active-high reset
 start  in  1  job request, sampled in IDLE
 len  in  LenWidth  terms per lane, sampled with start
 busy  out  1  job in progress
 done  out  1  one-cycle pulse, job complete
 op_valid  in  1  operand pair available
 op_ready  out  1  operand pair accepted this cycle
 op_w, op_i  in  DataWidth  FP32 weight, input
 mac_nop  out  1  to MAC NOPIn; 1 = bubble slot
 mac_w, mac_i, mac_o  out  DataWidth  to MAC W_Data, I_Data, O_Data
 mac_data  in  DataWidth  from MAC DataOut
 res_valid  out  1  result strobe
 res_lane  out  clog2(Lanes)  lane of result
 res_data  out  DataWidth  final lane sum

Function
REQ-004 SHALL compute Lanes independent dot products, lane j = sum over k<len of w*i; operands arrive lane-major: round 0 lanes 0..Lanes-1, round 1 lanes 0..Lanes-1, etc.
REQ-005 SHALL have states IDLE, ISSUE, DRAIN.
REQ-006 IDLE: start=1 with len!=0 latches len, clears slot s, expected lane e, round r, final bits; next state ISSUE. start with len==0, or start outside IDLE, SHALL be ignored.
REQ-007 Slot counter s SHALL advance every cycle in ISSUE/DRAIN, wrapping Lanes-1 -> 0; slot s owns lane s.
REQ-008 op_ready SHALL be combinational: 1 only in ISSUE with s==e; accept = op_valid & op_ready.
REQ-009 On accept: mac_w=op_w, mac_i=op_i, mac_nop=0; e increments; wrap Lanes-1 -> 0 increments r.
REQ-010 Non-accept slot: mac_w=mac_i=+0.0, mac_nop=1 (recirculation; -0.0 sums may become +0.0, accepted).
REQ-011 mac_o SHALL be +0.0 when lane s has zero issued terms (r==0 and s>=e), else mac_data, combinational.
REQ-012 A value issued in slot s at cycle t SHALL be consumed from mac_data at cycle t+Lanes (same slot); no other timing assumed.
REQ-013 Accept at lane j in round len-1 SHALL set final[j]; accept at lane Lanes-1 in round len-1 -> DRAIN.
REQ-014 In slot j with final[j]=1 (Lanes cycles after final issue): register res_data=mac_data, res_lane=j, res_valid=1 next cycle for one cycle; clear final[j].
REQ-015 Results SHALL emerge in lane order 0..Lanes-1, exactly Lanes per job.
REQ-016 done SHALL pulse coincident with res_valid for lane Lanes-1; state returns IDLE same edge; busy=0 from that cycle on.
REQ-017 DRAIN: op_ready=0, mac_nop=1, mac_w=mac_i=+0.0.
REQ-018 busy SHALL be 1 in ISSUE and DRAIN, 0 in IDLE.
REQ-019 op_valid stalls SHALL only delay acceptance by whole Lanes-cycle rotations; lane sums unaffected.

Reset
REQ-020 aclr SHALL force IDLE, s=e=r=0, final=0, busy=done=res_valid=0, res_lane=0, res_data=0, mac_nop=1 immediately, including mid-job; the job is abandoned, no results.

Structure
REQ-021 State encoding, Lanes default (MUL 5 + ADD 7) and FP32 zero constant SHALL live in the shared convolution-engine package.
REQ-022 Single flat module; no sub-module; the MAC pipeline is instantiated by the parent, not inside this block.

Verification
REQ-023 Bench SHALL pair the block with the real MAC pipeline and cover:
 len=1, all op w=2.0, i=3.0, op_valid=1 -> 12 results 6.0, lanes 0..11, done with lane 11.
 len=4, op_valid=1, w=1.0, i=j+1.0 -> lane j = 4(j+1); start cycle 0, accepts cycles 1..48, lane 0 res_valid cycle 50.
 len=3, op_valid=0 for 5 cycles at round 1 lane 3 -> op_ready next high 12 cycles later; sums identical to no-stall run.
 start with len=0, and start while busy -> ignored, no busy change, no results.
 aclr pulsed mid-ISSUE (round 2, len=5), then new job len=2 w=1.0 i=1.0 -> no stale results; all lanes 2.0.
 -0.0 products only, len=2 -> results zero (sign not checked), no X on outputs.
